mem_sequencer: RTL and testbench
================================

Name: mem_sequencer

Overview:
- Instruction-driven initiator for the register/stack memory block: fetches a program word at the memory's current PC and decodes it.
- Issues the memory's control strobes for one cycle per instruction: address, write enable, source select, PC step control, call/ret/push/pop.
- Sits between the program ROM and the memory; the memory remains the sole owner of PC, link and register state.

Parameters:
- INSTR_W, 17, program word width: op [16:13], addr field [12:8], literal [7:0].
- CNT_W, 8, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- pc_in  input  8  PC value presented by the memory.
- instr  input  INSTR_W  program ROM read data, valid one cycle after rom_addr.
- ceenz  input  1  condition flag forwarded to the memory for SKIP.
- step  input  1  single-step request; used only with the optional feature.
- rom_addr  output  8  program ROM address.
- mem_addr  output  5  memory address.
- wr_en  output  1  memory write strobe.
- csrc  output  2  memory source select: 00 data_in, 01 literal, 10 AMBA, 11 CEE.
- cpc  output  2  PC control: 0 hold, 1 +1, 2 conditional.
- call, ret, push, pop  output  1 each  memory stack strobes.
- literal  output  8  literal operand.
- halted  output  1  high while in the HALT state.
- retired  output  CNT_W  count of executed instructions.
- ceenz_o  output  1  registered copy of ceenz, sampled in DECODE.

Behaviour:
- Reset (rst low, asynchronous):
  - State = FETCH; IR = 0.
  - All outputs 0, including rom_addr, mem_addr, csrc, cpc, strobes, retired and halted.
- States and transitions:
  - FETCH → DECODE: rom_addr <= pc_in.
  - DECODE → EXEC: IR <= instr; ceenz_o <= ceenz; mem_addr <= IR addr field; literal <= IR literal.
  - EXEC → FETCH, except HALT → HALT.
- Control outputs are registered. In EXEC, wr_en=1 for exactly one clk and all strobes are driven per opcode.
- All strobes and wr_en are forced 0 in every state except EXEC. Throughput is one instruction per 3 clks.
- Opcode decode in EXEC (csrc, cpc, strobe):
  - 0 NOP: csrc 00, cpc 1. Integration ties data_in to data_out, so the write is a rewrite of the same value.
  - 1 MOVL: csrc 01, cpc 1.
  - 2 LD: csrc 00, cpc 1.
  - 3 AMBA: csrc 10, cpc 1.
  - 4 CEE: csrc 11, cpc 1.
  - 5 SKIP: csrc 00, cpc 2. PC advances 1 if ceenz_o=1, else 2.
  - 6 CALL: csrc 01, cpc 0, call=1.
  - 7 RET: csrc 00, cpc 0, ret=1.
  - 8 PUSH: csrc 00, cpc 1, push=1.
  - 9 POP: csrc 00, cpc 1, pop=1.
  - F HALT: wr_en=0, cpc 0; halted=1; no further fetch until reset.
  - A–E: treated as NOP.
- At most one of call/ret/push/pop is high in any cycle.
- retired increments on each EXEC except HALT. It saturates at all-ones and does not wrap.
- rom_addr wraps naturally with the 8-bit PC; pc_in 0xFF fetches from 0xFF.
- Reset asserted mid-EXEC: strobes drop immediately (asynchronously); the memory sees no rising edge with wr_en=1 from the aborted instruction once rst is low.
- Release of rst takes effect on the next clk edge: first FETCH.

Optional Feature:
- Macro: MEM_SEQUENCER_SINGLE_STEP_EN.
- Defined:
  - FETCH is entered only on a cycle where step=1; otherwise the FSM waits in an idle hold with all strobes 0.
  - One step pulse executes exactly one instruction. step held high runs continuously.
- Undefined: step is ignored and the sequencer free-runs.

Test Plan:
- Reset then pc_in=0x00, instr=MOVL addr 0x03 lit 0x5A → third clk after reset release: wr_en=1, mem_addr=0x03, csrc=01, literal=0x5A, cpc=1; retired=1.
- SKIP with ceenz=0 → cpc=2 in EXEC, ceenz_o=0. With ceenz=1 → ceenz_o=1; no stack strobes in either case.
- CALL addr 0x0C lit 0x40, then RET → call high one clk with cpc=0, then ret high one clk in the next EXEC; never both high together.
- HALT → halted=1, wr_en stays 0 for 20 clks, retired frozen. Reset → halted=0, retired=0.
- 300 NOPs → retired=0xFF and holds.
- Pull rst low during EXEC of PUSH → push and wr_en are 0 before the next clk edge; after release, rom_addr reloads from pc_in.

Source files
------------

// File: rtl/mem_sequencer.sv
// mem_sequencer: instruction-driven initiator for the register/stack memory.
// Each instruction takes three clocks: FETCH (drive ROM address from the
// memory's PC), DECODE (capture the program word and register the control
// strobes), EXEC (strobes visible to the memory for exactly one clock).
// Optional feature macro: MEM_SEQUENCER_SINGLE_STEP_EN -- when defined, FETCH
// only advances on a cycle where step=1; otherwise step is ignored.
module mem_sequencer #(
    parameter int unsigned INSTR_W = 17,
    parameter int unsigned CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         pc_in,
    input  logic [INSTR_W-1:0] instr,
    input  logic               ceenz,
    input  logic               step,
    output logic [7:0]         rom_addr,
    output logic [4:0]         mem_addr,
    output logic               wr_en,
    output logic [1:0]         csrc,
    output logic [1:0]         cpc,
    output logic               call,
    output logic               ret,
    output logic               push,
    output logic               pop,
    output logic [7:0]         literal,
    output logic               halted,
    output logic [CNT_W-1:0]   retired,
    output logic               ceenz_o
);

    typedef enum logic [1:0] {
        StFetch,
        StDecode,
        StExec,
        StHalt
    } state_e;

    localparam logic [3:0] OpNop  = 4'h0;
    localparam logic [3:0] OpMovl = 4'h1;
    localparam logic [3:0] OpLd   = 4'h2;
    localparam logic [3:0] OpAmba = 4'h3;
    localparam logic [3:0] OpCee  = 4'h4;
    localparam logic [3:0] OpSkip = 4'h5;
    localparam logic [3:0] OpCall = 4'h6;
    localparam logic [3:0] OpRet  = 4'h7;
    localparam logic [3:0] OpPush = 4'h8;
    localparam logic [3:0] OpPop  = 4'h9;
    localparam logic [3:0] OpHalt = 4'hF;

    localparam logic [CNT_W-1:0] RetiredMax = {CNT_W{1'b1}};

    state_e             state_q, state_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [7:0]         rom_addr_q, rom_addr_d;
    logic               ceenz_o_q, ceenz_o_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic               wr_en_q, wr_en_d;
    logic [1:0]         csrc_q, csrc_d;
    logic [1:0]         cpc_q, cpc_d;
    logic               call_q, call_d;
    logic               ret_q, ret_d;
    logic               push_q, push_d;
    logic               pop_q, pop_d;

    logic [3:0] instr_op;
    logic [3:0] ir_op;

    assign instr_op = instr[INSTR_W-1 -: 4];
    assign ir_op    = ir_q[INSTR_W-1 -: 4];

    // Next-state and registered-control decode; strobes default low so they
    // are only ever high during the single EXEC cycle.
    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        rom_addr_d = rom_addr_q;
        ceenz_o_d  = ceenz_o_q;
        retired_d  = retired_q;
        wr_en_d    = 1'b0;
        csrc_d     = 2'b00;
        cpc_d      = 2'd0;
        call_d     = 1'b0;
        ret_d      = 1'b0;
        push_d     = 1'b0;
        pop_d      = 1'b0;

        case (state_q)
            StFetch: begin
`ifdef MEM_SEQUENCER_SINGLE_STEP_EN
                if (step) begin
                    state_d    = StDecode;
                    rom_addr_d = pc_in;
                end
`else
                state_d    = StDecode;
                rom_addr_d = pc_in;
`endif
            end
            StDecode: begin
                state_d   = StExec;
                ir_d      = instr;
                ceenz_o_d = ceenz;
                if (instr_op != OpHalt) begin
                    wr_en_d = 1'b1;
                    cpc_d   = 2'd1;
                    if (retired_q != RetiredMax) begin
                        retired_d = retired_q + 1'b1;
                    end
                    case (instr_op)
                        OpMovl: csrc_d = 2'b01;
                        OpLd:   csrc_d = 2'b00;
                        OpAmba: csrc_d = 2'b10;
                        OpCee:  csrc_d = 2'b11;
                        OpSkip: cpc_d  = 2'd2;
                        OpCall: begin
                            csrc_d = 2'b01;
                            cpc_d  = 2'd0;
                            call_d = 1'b1;
                        end
                        OpRet: begin
                            cpc_d = 2'd0;
                            ret_d = 1'b1;
                        end
                        OpPush:  push_d = 1'b1;
                        OpPop:   pop_d  = 1'b1;
                        OpNop:   csrc_d = 2'b00;
                        default: csrc_d = 2'b00;
                    endcase
                end
            end
            StExec: begin
                state_d = (ir_op == OpHalt) ? StHalt : StFetch;
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StFetch;
            end
        endcase
    end

    // All sequencer state; async reset also drops any in-flight EXEC strobes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StFetch;
            ir_q       <= '0;
            rom_addr_q <= '0;
            ceenz_o_q  <= 1'b0;
            retired_q  <= '0;
            wr_en_q    <= 1'b0;
            csrc_q     <= 2'b00;
            cpc_q      <= 2'd0;
            call_q     <= 1'b0;
            ret_q      <= 1'b0;
            push_q     <= 1'b0;
            pop_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            rom_addr_q <= rom_addr_d;
            ceenz_o_q  <= ceenz_o_d;
            retired_q  <= retired_d;
            wr_en_q    <= wr_en_d;
            csrc_q     <= csrc_d;
            cpc_q      <= cpc_d;
            call_q     <= call_d;
            ret_q      <= ret_d;
            push_q     <= push_d;
            pop_q      <= pop_d;
        end
    end

    // Operand fields are views of the instruction register.
    assign mem_addr = ir_q[12:8];
    assign literal  = ir_q[7:0];
    assign rom_addr = rom_addr_q;
    assign ceenz_o  = ceenz_o_q;
    assign retired  = retired_q;
    assign wr_en    = wr_en_q;
    assign csrc     = csrc_q;
    assign cpc      = cpc_q;
    assign call     = call_q;
    assign ret      = ret_q;
    assign push     = push_q;
    assign pop      = pop_q;
    assign halted   = (state_q == StHalt);

endmodule

// File: tb/tb_mem_sequencer.sv
// Self-checking bench for mem_sequencer: directed scenarios plus randomized
// instructions compared against a per-instruction behavioural model.
module tb_mem_sequencer;

    localparam int unsigned INSTR_W = 17;
    localparam int unsigned CNT_W   = 8;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic               clk;
    logic               rst;
    logic [7:0]         pc_in;
    logic [INSTR_W-1:0] instr;
    logic               ceenz;
    logic               step;
    logic [7:0]         rom_addr;
    logic [4:0]         mem_addr;
    logic               wr_en;
    logic [1:0]         csrc;
    logic [1:0]         cpc;
    logic               call;
    logic               ret;
    logic               push;
    logic               pop;
    logic [7:0]         literal;
    logic               halted;
    logic [CNT_W-1:0]   retired;
    logic               ceenz_o;

    int checks;
    int errors;
    int model_retired;

    mem_sequencer #(
        .INSTR_W(INSTR_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .pc_in   (pc_in),
        .instr   (instr),
        .ceenz   (ceenz),
        .step    (step),
        .rom_addr(rom_addr),
        .mem_addr(mem_addr),
        .wr_en   (wr_en),
        .csrc    (csrc),
        .cpc     (cpc),
        .call    (call),
        .ret     (ret),
        .push    (push),
        .pop     (pop),
        .literal (literal),
        .halted  (halted),
        .retired (retired),
        .ceenz_o (ceenz_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock, then sample safely after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected EXEC controls per opcode, straight from the opcode table.
    typedef struct packed {
        logic       wr;
        logic [1:0] src;
        logic [1:0] pcc;
        logic       c;
        logic       r;
        logic       pu;
        logic       po;
    } ctl_t;

    function automatic ctl_t expect_ctl(input logic [3:0] op);
        ctl_t e;
        e = '{wr: 1'b1, src: 2'b00, pcc: 2'd1, c: 1'b0, r: 1'b0, pu: 1'b0, po: 1'b0};
        if (op == 4'h1) e.src = 2'b01;
        if (op == 4'h3) e.src = 2'b10;
        if (op == 4'h4) e.src = 2'b11;
        if (op == 4'h5) e.pcc = 2'd2;
        if (op == 4'h6) begin e.src = 2'b01; e.pcc = 2'd0; e.c = 1'b1; end
        if (op == 4'h7) begin e.pcc = 2'd0; e.r = 1'b1; end
        if (op == 4'h8) e.pu = 1'b1;
        if (op == 4'h9) e.po = 1'b1;
        if (op == 4'hF) e = '0;
        return e;
    endfunction

    // Run one full instruction from the FETCH phase; checks every phase.
    task automatic run_instr(input logic [7:0] pc, input logic [3:0] op, input logic [4:0] a,
                             input logic [7:0] lit, input logic cz);
        ctl_t e;
        pc_in = pc;
        tick();
        check("rom_addr", rom_addr, pc);
        check("fetch_wr", wr_en, 0);
        instr = {op, a, lit};
        ceenz = cz;
        tick();
        e = expect_ctl(op);
        if (op != 4'hF) model_retired = (model_retired + 1 > CNT_MAX) ? CNT_MAX : model_retired + 1;
        check("exec_wr", wr_en, e.wr);
        check("exec_csrc", csrc, e.src);
        check("exec_cpc", cpc, e.pcc);
        check("exec_call", call, e.c);
        check("exec_ret", ret, e.r);
        check("exec_push", push, e.pu);
        check("exec_pop", pop, e.po);
        check("stack_onehot", ($countones({call, ret, push, pop}) <= 1), 1);
        check("mem_addr", mem_addr, a);
        check("literal", literal, lit);
        check("ceenz_o", ceenz_o, cz);
        check("retired", retired, model_retired);
        check("halted_exec", halted, 0);
        tick();
        check("post_strobes", {wr_en, call, ret, push, pop, cpc}, 0);
        check("post_retired", retired, model_retired);
        check("post_halted", halted, (op == 4'hF));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #2;
        check("rst_outs", {rom_addr, mem_addr, wr_en, csrc, cpc, call, ret, push, pop}, 0);
        check("rst_lit", literal, 0);
        check("rst_halted", halted, 0);
        check("rst_retired", retired, 0);
        check("rst_ceenz_o", ceenz_o, 0);
        tick();
        tick();
        rst = 1'b1;
        model_retired = 0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        model_retired = 0;
        pc_in = 8'h00;
        instr = '0;
        ceenz = 1'b0;
        step  = 1'b1;
        rst   = 1'b1;
        #3;
        do_reset();

        // MOVL addr 0x03 lit 0x5A at PC 0.
        run_instr(8'h00, 4'h1, 5'h03, 8'h5A, 1'b0);
        // SKIP with both condition values.
        run_instr(8'h01, 4'h5, 5'h00, 8'h00, 1'b0);
        run_instr(8'h02, 4'h5, 5'h00, 8'h00, 1'b1);
        // CALL then RET.
        run_instr(8'h03, 4'h6, 5'h0C, 8'h40, 1'b0);
        run_instr(8'h40, 4'h7, 5'h00, 8'h00, 1'b0);
        // PC at the top of the address space.
        run_instr(8'hFF, 4'h2, 5'h1F, 8'hFF, 1'b1);

        // Randomized non-HALT instructions.
        for (int i = 0; i < 60; i++) begin
            logic [3:0] op;
            op = 4'($urandom_range(0, 14));
            run_instr(8'($urandom), op, 5'($urandom), 8'($urandom), 1'($urandom));
        end

        // HALT: stays halted, no writes, counter frozen.
        run_instr(8'h10, 4'hF, 5'h05, 8'h11, 1'b0);
        for (int i = 0; i < 20; i++) begin
            pc_in = 8'($urandom);
            tick();
            check("halt_wr", {wr_en, cpc}, 0);
            check("halt_flag", halted, 1);
            check("halt_retired", retired, model_retired);
        end
        do_reset();
        check("reset_unhalt", halted, 0);

        // Saturation of the retired counter.
        for (int i = 0; i < 300; i++) begin
            run_instr(8'(i), 4'h0, 5'($urandom), 8'($urandom), 1'b0);
        end
        check("retired_sat", retired, 8'hFF);

        // Reset during EXEC of PUSH drops strobes asynchronously.
        pc_in = 8'h20;
        tick();
        instr = {4'h8, 5'h07, 8'h00};
        tick();
        check("push_exec", push, 1);
        #2;
        rst = 1'b0;
        #1;
        check("abort_push", push, 0);
        check("abort_wr", wr_en, 0);
        tick();
        rst = 1'b1;
        model_retired = 0;
        run_instr(8'h77, 4'h1, 5'h02, 8'h33, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
